fwd_hazard_ctrl: RTL and testbench



---
 rtl/fwd_pkg.sv | 17 +
 rtl/fwd_hazard_ctrl_match.sv | 36 +++
 rtl/fwd_hazard_ctrl.sv | 77 +++++++
 tb/tb_fwd_hazard_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EX-stage forwarding / load-use hazard controller.
package fwd_pkg;

  localparam int FWD_RD_W   = 16;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                wr;
    logic                ld;
    logic [FWD_RD_W-1:0] rd;
  } fwd_entry_t;

  function automatic int stage_sel(input int depth, input int k);
    return depth - k + 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_match.sv
// One operand's priority scan over the tracked post-EX stages.
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  fwd_entry_t [FWD_DEPTH-1:0] stages,
  input  logic [REG_ADDR_W-1:0]      src,
  output logic [SEL_W-1:0]           sel,
  output logic                       not_ready
);

  logic found;

  // stages[0] is EX/MEM; the youngest matching writer wins
  always_comb begin
    sel       = SEL_W'(FWD_SEL_RF);
    not_ready = 1'b0;
    found     = 1'b0;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      if (!found && stages[k-1].wr &&
          (stages[k-1].rd != '0) &&
          (stages[k-1].rd == FWD_RD_W'(src))) begin
        found = 1'b1;
        if (stages[k-1].ld && (k <= LOAD_LAT))
          not_ready = 1'b1;
        else
          sel = SEL_W'(stage_sel(FWD_DEPTH, k));
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall generation for the EX stage.
// Optional stall counter output enabled by FWD_STALL_CNT_EN.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_DEPTH  = 2,
  parameter int LOAD_LAT   = 1,
  parameter int SEL_W      = $clog2(FWD_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic                          flush,
  input  logic                          ex_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_src,
  input  logic                          ex_regwrite,
  input  logic [REG_ADDR_W-1:0]         ex_rd,
  input  logic                          ex_is_load,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]                   stall_cnt,
`endif
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall
);

  fwd_entry_t [FWD_DEPTH-1:0] st;
  fwd_entry_t                 ent;
  logic [NUM_SRC-1:0]         nr;
  logic                       go;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_ADDR_W(REG_ADDR_W),
      .FWD_DEPTH (FWD_DEPTH),
      .LOAD_LAT  (LOAD_LAT),
      .SEL_W     (SEL_W)
    ) u_match (
      .stages   (st),
      .src      (ex_src[i*REG_ADDR_W +: REG_ADDR_W]),
      .sel      (fwd_sel[i*SEL_W +: SEL_W]),
      .not_ready(nr[i])
    );
  end

  assign stall = ex_valid & ~flush & (|nr);
  assign go    = ex_valid & ~flush & ~stall;

  always_comb begin
    ent    = '0;
    ent.wr = ex_regwrite;
    ent.ld = ex_is_load;
    ent.rd = FWD_RD_W'(ex_rd);
  end

  // a stalled or flushed EX slot enters tracking as a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '0;
    end else if (!hold) begin
      st[0] <= go ? ent : '0;
      for (int k = 1; k < FWD_DEPTH; k++)
        st[k] <= st[k-1];
    end
  end

`ifdef FWD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && !hold && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: default build plus FWD_DEPTH=3/LOAD_LAT=2.
module tb_fwd_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic       hold;
    logic       flush;
    logic       valid;
    logic       rw;
    logic       ld;
    logic [4:0] rd;
    logic [4:0] s0;
    logic [4:0] s1;
  } vec_t;

  typedef struct {
    int         d;
    logic [3:0] sel;
    logic       stall;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  vec_t ia, ib;
  logic [3:0] sel_a, sel_b;
  logic stall_a, stall_b;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] cnt_a, cnt_b;
`endif

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  fwd_hazard_ctrl u_a (
    .clk        (clk),
    .rst        (ia.rst),
    .hold       (ia.hold),
    .flush      (ia.flush),
    .ex_valid   (ia.valid),
    .ex_src     ({ia.s1, ia.s0}),
    .ex_regwrite(ia.rw),
    .ex_rd      (ia.rd),
    .ex_is_load (ia.ld),
`ifdef FWD_STALL_CNT_EN
    .stall_cnt  (cnt_a),
`endif
    .fwd_sel    (sel_a),
    .stall      (stall_a)
  );

  fwd_hazard_ctrl #(.FWD_DEPTH(3), .LOAD_LAT(2)) u_b (
    .clk        (clk),
    .rst        (ib.rst),
    .hold       (ib.hold),
    .flush      (ib.flush),
    .ex_valid   (ib.valid),
    .ex_src     ({ib.s1, ib.s0}),
    .ex_regwrite(ib.rw),
    .ex_rd      (ib.rd),
    .ex_is_load (ib.ld),
`ifdef FWD_STALL_CNT_EN
    .stall_cnt  (cnt_b),
`endif
    .fwd_sel    (sel_b),
    .stall      (stall_b)
  );

  function automatic vec_t mk(input logic valid, input logic rw,
                              input logic ld, input logic [4:0] rd,
                              input logic [4:0] s0, input logic [4:0] s1);
    vec_t v;
    v.rst = 1'b0; v.hold = 1'b0; v.flush = 1'b0;
    v.valid = valid; v.rw = rw; v.ld = ld;
    v.rd = rd; v.s0 = s0; v.s1 = s1;
    return v;
  endfunction

  task automatic push(input int d, input logic [3:0] es,
                      input logic est, input string nm);
    exp_t e;
    e.d = d; e.sel = es; e.stall = est; e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(input int d, input vec_t v, input logic [3:0] es,
                      input logic est, input string nm);
    @(posedge clk);
    #1;
    ia = (d == 0) ? v : mk(0, 0, 0, 0, 0, 0);
    ib = (d == 1) ? v : mk(0, 0, 0, 0, 0, 0);
    push(d, es, est, nm);
  endtask

  // monitor: outputs are sampled mid-cycle, away from the rising edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [3:0] s;
      logic t;
      e = q.pop_front();
      s = (e.d == 0) ? sel_a : sel_b;
      t = (e.d == 0) ? stall_a : stall_b;
      checks++;
      if (s !== e.sel || t !== e.stall) begin
        errors++;
        $display("FAIL %s: got sel=%h stall=%b, want sel=%h stall=%b",
                 e.name, s, t, e.sel, e.stall);
      end
    end
  end

  initial begin
    vec_t v;
    ia = mk(0, 0, 0, 0, 0, 0);
    ib = mk(0, 0, 0, 0, 0, 0);
    ia.rst = 1'b1;
    ib.rst = 1'b1;
    @(posedge clk);
    #1;
    push(0, 4'h0, 1'b0, "reset_a");
    push(1, 4'h0, 1'b0, "reset_b");

    // ALU chain
    step(0, mk(1, 1, 0, 3, 1, 2), 4'b0000, 0, "add_r3");
    step(0, mk(1, 1, 0, 5, 3, 4), 4'b0010, 0, "sub_fwd_exmem");
    step(0, mk(1, 1, 0, 7, 3, 5), 4'b1001, 0, "and_two_stage");
    step(0, mk(0, 0, 0, 0, 0, 0), 4'b0000, 0, "idle1");
    step(0, mk(0, 0, 0, 0, 0, 0), 4'b0000, 0, "idle2");

    // load-use, back to back
    step(0, mk(1, 1, 1, 1, 0, 0), 4'b0000, 0, "lw_r1");
    step(0, mk(1, 1, 0, 8, 1, 0), 4'b0000, 1, "lw_use_stall");
    step(0, mk(1, 1, 0, 8, 1, 0), 4'b0001, 0, "lw_use_fwd");
    step(0, mk(0, 0, 0, 0, 0, 0), 4'b0000, 0, "idle3");

    // youngest writer wins
    step(0, mk(1, 1, 0, 6, 0, 0), 4'b0000, 0, "wr_r6_a");
    step(0, mk(1, 1, 0, 6, 0, 0), 4'b0000, 0, "wr_r6_b");
    step(0, mk(1, 1, 0, 9, 6, 6), 4'b1010, 0, "xor_youngest");

    // r0 never forwards nor stalls
    step(0, mk(1, 1, 1, 0, 0, 0), 4'b0000, 0, "lw_r0");
    step(0, mk(1, 1, 0, 4, 0, 0), 4'b0000, 0, "use_r0");

    // stall under hold
    step(0, mk(1, 1, 1, 10, 0, 0), 4'b0000, 0, "lw_r10");
    v = mk(1, 1, 0, 11, 10, 0);
    v.hold = 1'b1;
    step(0, v, 4'b0000, 1, "hold_stall1");
    step(0, v, 4'b0000, 1, "hold_stall2");
    step(0, v, 4'b0000, 1, "hold_stall3");
    v.hold = 1'b0;
    step(0, v, 4'b0000, 1, "unhold_stall");
    step(0, v, 4'b0001, 0, "unhold_release");

    // flush beats stall
    step(0, mk(1, 1, 1, 12, 0, 0), 4'b0000, 0, "lw_r12");
    v = mk(1, 1, 0, 14, 12, 0);
    v.flush = 1'b1;
    step(0, v, 4'b0000, 0, "flush_prio");
    step(0, mk(1, 1, 0, 14, 0, 12), 4'b0100, 0, "after_flush");

    // reset mid-stall
    step(0, mk(1, 1, 1, 13, 0, 0), 4'b0000, 0, "lw_r13");
    v = mk(1, 1, 0, 15, 13, 0);
    step(0, v, 4'b0000, 1, "pre_rst_stall");
    v.rst = 1'b1;
    step(0, v, 4'b0000, 0, "rst_mid_stall");
    step(0, mk(1, 1, 0, 15, 13, 14), 4'b0000, 0, "post_rst_bubbles");

    // deep pipeline: FWD_DEPTH=3, LOAD_LAT=2
    step(1, mk(1, 1, 0, 4, 0, 0), 4'b0000, 0, "b_add_r4");
    step(1, mk(1, 1, 1, 2, 4, 0), 4'b0011, 0, "b_lw_fwd_k1");
    step(1, mk(1, 1, 0, 5, 2, 4), 4'b1000, 1, "b_stall1");
    step(1, mk(1, 1, 0, 5, 2, 4), 4'b0100, 1, "b_stall2");
    step(1, mk(1, 1, 0, 5, 2, 4), 4'b0001, 0, "b_release");

    @(posedge clk);
    #1;
    ia = mk(0, 0, 0, 0, 0, 0);
    ib = mk(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", q.size());
    end
`ifdef FWD_STALL_CNT_EN
    checks++;
    if (cnt_b !== 32'd2) begin
      errors++;
      $display("FAIL b_stall_cnt: got %0d, want 2", cnt_b);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
